// File: rtl/acc_dma_if.sv
// Bus bundle for acc_dma: command, memory, accelerator control and both stream ports.
// master = DMA side, slave = memory/accelerator/host side.
interface acc_dma_if #(
    parameter int ADDR_W = 12,
    parameter int LEN_W  = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_sel;
    logic [ADDR_W-1:0] cmd_src_addr;
    logic [ADDR_W-1:0] cmd_dst_addr;
    logic [LEN_W-1:0]  cmd_src_len;
    logic [LEN_W-1:0]  cmd_dst_len;
    logic              done;
    logic [1:0]        err;

    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [31:0]       mem_rd_data;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [31:0]       mem_wr_data;

    logic [2:0]        acc_ap_start;
    logic              acc_ap_idle;

    logic              mm_tvalid;
    logic [31:0]       mm_tdata;
    logic              mm_tlast;
    logic              mm_tready;

    logic              sr_tvalid;
    logic [31:0]       sr_tdata;
    logic              sr_tlast;
    logic              sr_tready;

    modport master (
        input  cmd_valid, cmd_sel, cmd_src_addr, cmd_dst_addr, cmd_src_len, cmd_dst_len,
        output cmd_ready, done, err,
        output mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
        input  mem_rd_data,
        output acc_ap_start,
        input  acc_ap_idle,
        output mm_tvalid, mm_tdata, mm_tlast,
        input  mm_tready,
        input  sr_tvalid, sr_tdata, sr_tlast,
        output sr_tready
    );

    modport slave (
        output cmd_valid, cmd_sel, cmd_src_addr, cmd_dst_addr, cmd_src_len, cmd_dst_len,
        input  cmd_ready, done, err,
        input  mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
        output mem_rd_data,
        input  acc_ap_start,
        output acc_ap_idle,
        input  mm_tvalid, mm_tdata, mm_tlast,
        output mm_tready,
        output sr_tvalid, sr_tdata, sr_tlast,
        input  sr_tready
    );
endinterface

// File: rtl/acc_dma.sv
// Command-driven stream DMA: memory -> accelerator stream, accelerator stream -> memory.
// Optional RUN watchdog (err[1]) enabled by defining ACC_DMA_TIMEOUT_EN.
//
// state   | meaning
// S_IDLE  | cmd_ready high, waiting for a command
// S_START | waiting for acc_ap_idle, then one-cycle acc_ap_start pulse
// S_RUN   | prefetching/streaming source words and writing back results
// S_DONE  | one-cycle done pulse
module acc_dma #(
    parameter int ADDR_W = 12,
    parameter int LEN_W  = 8
) (
    input logic       clk,
    input logic       rst,
    acc_dma_if.master bus
);
    localparam int CW = LEN_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_DONE} state_t;
    state_t state, state_nxt;

    logic [2:0]        sel;
    logic [ADDR_W-1:0] src_addr, dst_addr;
    logic [CW-1:0]     src_len, dst_len, issued, sent, rx_cnt;
    logic [31:0]       fifo_mem [2];
    logic              wr_ptr, rd_ptr, rd_pend;
    logic [1:0]        fifo_cnt, occ;
    logic [1:0]        err_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [31:0]       wr_data_q;
    logic              cmd_acc, mm_valid, mm_pop, sr_rdy, sr_hs, rd_issue, rx_last, wd_fire;

`ifdef ACC_DMA_TIMEOUT_EN
    logic [9:0] wd_cnt;

    // Reaches zero after 1023 consecutive RUN cycles without a handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt <= 10'h3FF;
        end else if (state != S_RUN || mm_pop || sr_hs) begin
            wd_cnt <= 10'h3FF;
        end else if (wd_cnt != 10'd0) begin
            wd_cnt <= wd_cnt - 10'd1;
        end
    end

    assign wd_fire = (state == S_RUN) && (wd_cnt == 10'd0);
`else
    assign wd_fire = 1'b0;
`endif

    // A read may be issued in the same cycle a beat pops, which keeps 1 word/cycle.
    always_comb begin
        cmd_acc  = (state == S_IDLE) && bus.cmd_valid;
        occ      = fifo_cnt + {1'b0, rd_pend};
        mm_valid = (state == S_RUN) && (fifo_cnt != 2'd0) && !wd_fire;
        mm_pop   = mm_valid && bus.mm_tready;
        sr_rdy   = (state == S_RUN) && (rx_cnt < dst_len) && !wd_fire;
        sr_hs    = sr_rdy && bus.sr_tvalid;
        rd_issue = (state == S_RUN) && !wd_fire && (issued < src_len) &&
                   ((occ < 2'd2) || mm_pop);
        rx_last  = (rx_cnt == dst_len - CW'(1));
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    state_nxt = $onehot(bus.cmd_sel) ? S_START : S_DONE;
                end
            end
            S_START: begin
                if (bus.acc_ap_idle) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (wd_fire || ((sent == src_len) && (rx_cnt == dst_len) && !wr_en_q)) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            sel         <= 3'b000;
            src_addr    <= '0;
            dst_addr    <= '0;
            src_len     <= '0;
            dst_len     <= '0;
            issued      <= '0;
            sent        <= '0;
            rx_cnt      <= '0;
            fifo_mem[0] <= 32'h0;
            fifo_mem[1] <= 32'h0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            rd_pend     <= 1'b0;
            fifo_cnt    <= 2'd0;
            err_q       <= 2'b00;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= 32'h0;
        end else begin
            state   <= state_nxt;
            wr_en_q <= sr_hs;
            if (sr_hs) begin
                wr_addr_q <= dst_addr + ADDR_W'(rx_cnt);
                wr_data_q <= bus.sr_tdata;
            end
            if (cmd_acc) begin
                sel      <= bus.cmd_sel;
                src_addr <= bus.cmd_src_addr;
                dst_addr <= bus.cmd_dst_addr;
                src_len  <= {1'b0, bus.cmd_src_len};
                dst_len  <= {1'b0, bus.cmd_dst_len};
                issued   <= '0;
                sent     <= '0;
                rx_cnt   <= '0;
                wr_ptr   <= 1'b0;
                rd_ptr   <= 1'b0;
                rd_pend  <= 1'b0;
                fifo_cnt <= 2'd0;
                err_q    <= 2'b00;
            end else begin
                rd_pend <= rd_issue;
                if (rd_issue) issued <= issued + CW'(1);
                if (mm_pop)   sent   <= sent + CW'(1);
                if (sr_hs)    rx_cnt <= rx_cnt + CW'(1);
                if (rd_pend) begin
                    fifo_mem[wr_ptr] <= bus.mem_rd_data;
                    wr_ptr           <= ~wr_ptr;
                end
                if (mm_pop) rd_ptr <= ~rd_ptr;
                case ({rd_pend, mm_pop})
                    2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                    2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                    default: fifo_cnt <= fifo_cnt;
                endcase
                if (sr_hs && (bus.sr_tlast != rx_last)) err_q[0] <= 1'b1;
                if (wd_fire) err_q[1] <= 1'b1;
            end
        end
    end

    assign bus.cmd_ready    = (state == S_IDLE);
    assign bus.done         = (state == S_DONE);
    assign bus.err          = err_q;
    assign bus.acc_ap_start = ((state == S_START) && bus.acc_ap_idle) ? sel : 3'b000;
    assign bus.mem_rd_en    = rd_issue;
    assign bus.mem_rd_addr  = rd_issue ? (src_addr + ADDR_W'(issued)) : '0;
    assign bus.mem_wr_en    = wr_en_q;
    assign bus.mem_wr_addr  = wr_addr_q;
    assign bus.mem_wr_data  = wr_data_q;
    assign bus.mm_tvalid    = mm_valid;
    assign bus.mm_tdata     = mm_valid ? fifo_mem[rd_ptr] : 32'h0;
    assign bus.mm_tlast     = mm_valid && (sent == src_len - CW'(1));
    assign bus.sr_tready    = sr_rdy;
endmodule

// File: tb/tb_acc_dma.sv
// Self-checking bench for acc_dma: memory model, randomized accelerator stream model,
// reference expectations computed from addresses, lengths and generated data.
module tb_acc_dma;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    acc_dma_if #(.ADDR_W(12), .LEN_W(8)) bus ();
    acc_dma #(.ADDR_W(12), .LEN_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [31:0] mem [4096];
    logic [31:0] sr_gen [256];

    always @(posedge clk) if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_rd_addr];

    // Observation log, filled at negedge when all values for the coming edge are settled.
    logic [31:0] mm_q[$];
    bit          mm_last_q[$];
    logic [11:0] rd_q[$];
    logic [11:0] wa_q[$];
    logic [31:0] wd_q[$];
    int start_cnt, start_cyc, done_cnt, done_cyc, last_wr_cyc, last_hs_cyc, rx_hs, stall_bad;
    int first_mm_cyc, sr_shown;
    logic [2:0]  start_val;
    bit          prev_stall;
    logic [31:0] prev_data;
    logic        prev_last;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (!bus.mm_tvalid || bus.mm_tdata !== prev_data || bus.mm_tlast !== prev_last))
                stall_bad++;
            prev_stall = bus.mm_tvalid && !bus.mm_tready;
            prev_data  = bus.mm_tdata;
            prev_last  = bus.mm_tlast;
            if (bus.mm_tvalid && first_mm_cyc < 0) first_mm_cyc = cyc;
            if (bus.mm_tvalid && bus.mm_tready) begin
                mm_q.push_back(bus.mm_tdata);
                mm_last_q.push_back(bus.mm_tlast);
                last_hs_cyc = cyc;
            end
            if (bus.sr_tvalid && bus.sr_tready) begin
                rx_hs++;
                last_hs_cyc = cyc;
            end
            if (bus.mem_rd_en) rd_q.push_back(bus.mem_rd_addr);
            if (bus.mem_wr_en) begin
                wa_q.push_back(bus.mem_wr_addr);
                wd_q.push_back(bus.mem_wr_data);
                last_wr_cyc = cyc;
            end
            if (bus.acc_ap_start != 3'b000) begin
                start_cnt++;
                start_cyc = cyc;
                start_val = bus.acc_ap_start;
            end
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic clear_logs();
        mm_q.delete(); mm_last_q.delete(); rd_q.delete(); wa_q.delete(); wd_q.delete();
        start_cnt = 0; start_cyc = -1; done_cnt = 0; done_cyc = -1; last_wr_cyc = -1;
        last_hs_cyc = -1; rx_hs = 0; stall_bad = 0; first_mm_cyc = -1; sr_shown = -1;
        start_val = 3'b000;
    endtask

    // Reference model: stream out = mem[src+i], tlast only on i==slen-1.
    function automatic int mm_mism(logic [11:0] src, int slen);
        int e = (mm_q.size() != slen) ? 1 : 0;
        logic [11:0] a;
        for (int i = 0; i < mm_q.size() && i < slen; i++) begin
            a = src + 12'(i);
            if (mm_q[i] !== mem[a]) e++;
            if (mm_last_q[i] !== (i == slen - 1)) e++;
        end
        return e;
    endfunction

    // Reference model: write i goes to dst+i carrying the i-th accelerator word.
    function automatic int wr_mism(logic [11:0] dst, int n);
        int e = (wa_q.size() != n) ? 1 : 0;
        for (int i = 0; i < wa_q.size() && i < n; i++) begin
            if (wa_q[i] !== dst + 12'(i)) e++;
            if (wd_q[i] !== sr_gen[i]) e++;
        end
        return e;
    endfunction

    function automatic int rd_mism(logic [11:0] src, int slen);
        int e = (rd_q.size() != slen) ? 1 : 0;
        for (int i = 0; i < rd_q.size() && i < slen; i++)
            if (rd_q[i] !== src + 12'(i)) e++;
        return e;
    endfunction

    // Drives one command and plays the accelerator; last_at<0 means tlast on the final beat.
    task automatic run_cmd(input logic [2:0] sel, input logic [11:0] src, input logic [11:0] dst,
                           input int slen, input int dlen, input int ngen, input int mm_pct,
                           input int sr_pct, input int last_at, input int idle_delay,
                           input int max_cyc, output int cmd_cyc);
        clear_logs();
        for (int i = 0; i < 256; i++) sr_gen[i] = $urandom;
        @(posedge clk); #1;
        bus.cmd_valid    = 1'b1;
        bus.cmd_sel      = sel;
        bus.cmd_src_addr = src;
        bus.cmd_dst_addr = dst;
        bus.cmd_src_len  = 8'(slen);
        bus.cmd_dst_len  = 8'(dlen);
        bus.acc_ap_idle  = (idle_delay == 0);
        cmd_cyc = cyc;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        for (int n = 0; n < max_cyc && done_cnt == 0; n++) begin
            bus.acc_ap_idle = ((cyc - cmd_cyc) >= idle_delay);
            bus.mm_tready   = ($urandom_range(99) < mm_pct);
            if (bus.sr_tvalid && sr_shown == rx_hs) begin
                bus.sr_tvalid = 1'b1;
            end else if (rx_hs < ngen && $urandom_range(99) < sr_pct) begin
                sr_shown      = rx_hs;
                bus.sr_tvalid = 1'b1;
                bus.sr_tdata  = sr_gen[rx_hs];
                bus.sr_tlast  = (last_at >= 0) ? (rx_hs == last_at) : (rx_hs == dlen - 1);
            end else begin
                bus.sr_tvalid = 1'b0;
            end
            @(posedge clk); #1;
        end
        bus.mm_tready   = 1'b0;
        bus.sr_tvalid   = 1'b0;
        bus.sr_tlast    = 1'b0;
        bus.acc_ap_idle = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [11:0] ctl;
        logic [87:0] dat;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        ctl = {bus.cmd_ready, bus.done, bus.err, bus.acc_ap_start, bus.mm_tvalid, bus.mm_tlast,
               bus.sr_tready, bus.mem_rd_en, bus.mem_wr_en};
        dat = {bus.mm_tdata, bus.mem_rd_addr, bus.mem_wr_addr, bus.mem_wr_data};
        total++;
        if (ctl !== 12'b1000_0000_0000) begin bad++; $display("FAIL reset_ctl got=%b want=100000000000", ctl); end
        total++;
        if (dat !== 88'h0) begin bad++; $display("FAIL reset_data got=%h want=0", dat); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_fir();
        int cc;
        run_cmd(3'b001, 12'h100, 12'h200, 64, 64, 64, 100, 100, -1, 0, 400, cc);
        total++;
        if (start_cnt !== 1 || start_val !== 3'b001) begin bad++; $display("FAIL fir_start got cnt=%0d val=%b want 1/001", start_cnt, start_val); end
        total++;
        if (start_cyc !== cc + 1) begin bad++; $display("FAIL fir_start_lat got=%0d want=%0d", start_cyc - cc, 1); end
        total++;
        if (first_mm_cyc !== start_cyc + 3) begin bad++; $display("FAIL fir_first_valid got=%0d want=%0d", first_mm_cyc - start_cyc, 3); end
        total++;
        if (mm_mism(12'h100, 64) !== 0) begin bad++; $display("FAIL fir_mm got=%0d errors (beats=%0d) want=0", mm_mism(12'h100, 64), mm_q.size()); end
        total++;
        if (wr_mism(12'h200, 64) !== 0) begin bad++; $display("FAIL fir_wr got=%0d errors (writes=%0d) want=0", wr_mism(12'h200, 64), wa_q.size()); end
        total++;
        if (done_cnt !== 1 || bus.err !== 2'b00) begin bad++; $display("FAIL fir_done got done=%0d err=%b want 1/00", done_cnt, bus.err); end
        total++;
        if (done_cyc <= last_wr_cyc) begin bad++; $display("FAIL fir_done_after_wr got done=%0d last_wr=%0d", done_cyc, last_wr_cyc); end
        total++;
        if (done_cyc - cc > 75) begin bad++; $display("FAIL fir_throughput got=%0d cycles want<=75", done_cyc - cc); end
    endtask

    task automatic test_random_gaps();
        int cc;
        logic [11:0] s, d;
        for (int it = 0; it < 3; it++) begin
            s = 12'($urandom);
            d = 12'($urandom);
            run_cmd(3'b100, s, d, 10, 10, 10, 50, 50, -1, 0, 300, cc);
            total++;
            if (mm_mism(s, 10) !== 0) begin bad++; $display("FAIL gaps_mm it=%0d got=%0d errors want=0", it, mm_mism(s, 10)); end
            total++;
            if (wr_mism(d, 10) !== 0) begin bad++; $display("FAIL gaps_wr it=%0d got=%0d errors want=0", it, wr_mism(d, 10)); end
            total++;
            if (stall_bad !== 0) begin bad++; $display("FAIL gaps_stall it=%0d got=%0d want=0", it, stall_bad); end
            total++;
            if (done_cnt !== 1 || bus.err !== 2'b00) begin bad++; $display("FAIL gaps_done it=%0d got done=%0d err=%b want 1/00", it, done_cnt, bus.err); end
        end
    endtask

    task automatic test_wrap();
        int cc;
        run_cmd(3'b010, 12'hFFE, 12'h7F0, 4, 4, 4, 100, 100, -1, 0, 100, cc);
        total++;
        if (rd_mism(12'hFFE, 4) !== 0) begin bad++; $display("FAIL wrap_rd got=%0d errors (reads=%0d) want=0", rd_mism(12'hFFE, 4), rd_q.size()); end
        total++;
        if (mm_mism(12'hFFE, 4) !== 0) begin bad++; $display("FAIL wrap_mm got=%0d errors want=0", mm_mism(12'hFFE, 4)); end
    endtask

    task automatic test_tlast_err();
        int cc;
        run_cmd(3'b001, 12'h040, 12'h600, 8, 16, 16, 100, 100, 5, 0, 200, cc);
        total++;
        if (wr_mism(12'h600, 16) !== 0) begin bad++; $display("FAIL tlast_early_wr got=%0d errors want=0", wr_mism(12'h600, 16)); end
        total++;
        if (done_cnt !== 1 || bus.err !== 2'b01) begin bad++; $display("FAIL tlast_early_err got done=%0d err=%b want 1/01", done_cnt, bus.err); end
        run_cmd(3'b001, 12'h040, 12'h680, 3, 16, 16, 100, 100, 99, 0, 200, cc);
        total++;
        if (done_cnt !== 1 || bus.err !== 2'b01 || wa_q.size() !== 16) begin
            bad++; $display("FAIL tlast_missing got done=%0d err=%b writes=%0d want 1/01/16", done_cnt, bus.err, wa_q.size());
        end
    endtask

    task automatic test_idle_wait();
        int cc;
        run_cmd(3'b010, 12'h300, 12'h380, 5, 5, 5, 100, 100, -1, 20, 200, cc);
        total++;
        if (start_cnt !== 1 || start_val !== 3'b010) begin bad++; $display("FAIL idle_start got cnt=%0d val=%b want 1/010", start_cnt, start_val); end
        total++;
        if (start_cyc - cc !== 20) begin bad++; $display("FAIL idle_delay got=%0d want=20", start_cyc - cc); end
        total++;
        if (mm_mism(12'h300, 5) + wr_mism(12'h380, 5) !== 0 || bus.err !== 2'b00) begin
            bad++; $display("FAIL idle_data got=%0d errors err=%b want 0/00", mm_mism(12'h300, 5) + wr_mism(12'h380, 5), bus.err);
        end
    endtask

    task automatic test_invalid_sel();
        int cc;
        logic [2:0] bad_sel [2];
        bad_sel[0] = 3'b011;
        bad_sel[1] = 3'b000;
        for (int k = 0; k < 2; k++) begin
            run_cmd(bad_sel[k], 12'h010, 12'h020, 4, 4, 0, 100, 100, -1, 0, 20, cc);
            total++;
            if (done_cnt !== 1 || done_cyc !== cc + 1 || bus.err !== 2'b00) begin
                bad++; $display("FAIL invalid_done sel=%b got done=%0d lat=%0d err=%b want 1/1/00", bad_sel[k], done_cnt, done_cyc - cc, bus.err);
            end
            total++;
            if (rd_q.size() + wa_q.size() + start_cnt + mm_q.size() !== 0) begin
                bad++; $display("FAIL invalid_quiet sel=%b got activity=%0d want=0", bad_sel[k], rd_q.size() + wa_q.size() + start_cnt + mm_q.size());
            end
        end
    endtask

    task automatic test_zero_len();
        int cc;
        run_cmd(3'b001, 12'h500, 12'h540, 0, 3, 3, 100, 100, -1, 0, 100, cc);
        total++;
        if (rd_q.size() !== 0 || mm_q.size() !== 0 || wr_mism(12'h540, 3) !== 0 || done_cnt !== 1) begin
            bad++; $display("FAIL zero_src got reads=%0d beats=%0d wr_err=%0d done=%0d want 0/0/0/1", rd_q.size(), mm_q.size(), wr_mism(12'h540, 3), done_cnt);
        end
        run_cmd(3'b100, 12'h560, 12'h580, 5, 0, 0, 100, 100, -1, 0, 100, cc);
        total++;
        if (mm_mism(12'h560, 5) !== 0 || wa_q.size() !== 0 || done_cnt !== 1 || bus.err !== 2'b00) begin
            bad++; $display("FAIL zero_dst got mm_err=%0d writes=%0d done=%0d err=%b want 0/0/1/00", mm_mism(12'h560, 5), wa_q.size(), done_cnt, bus.err);
        end
    endtask

    task automatic test_reset_mid_run();
        int cc;
        logic [11:0] ctl;
        logic [87:0] dat;
        clear_logs();
        @(posedge clk); #1;
        bus.cmd_valid = 1'b1; bus.cmd_sel = 3'b001;
        bus.cmd_src_addr = 12'h700; bus.cmd_dst_addr = 12'h800;
        bus.cmd_src_len = 8'd50; bus.cmd_dst_len = 8'd50;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        bus.mm_tready = 1'b1; bus.sr_tvalid = 1'b1; bus.sr_tdata = 32'hDEAD_BEEF; bus.sr_tlast = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        total++;
        if (bus.mm_tvalid !== 1'b1 || bus.sr_tready !== 1'b1) begin bad++; $display("FAIL midrun_active got tvalid=%b tready=%b want 1/1", bus.mm_tvalid, bus.sr_tready); end
        rst = 1'b1;
        #1;
        ctl = {bus.cmd_ready, bus.done, bus.err, bus.acc_ap_start, bus.mm_tvalid, bus.mm_tlast,
               bus.sr_tready, bus.mem_rd_en, bus.mem_wr_en};
        dat = {bus.mm_tdata, bus.mem_rd_addr, bus.mem_wr_addr, bus.mem_wr_data};
        total++;
        if (ctl !== 12'b1000_0000_0000 || dat !== 88'h0) begin bad++; $display("FAIL midrun_reset got ctl=%b data=%h want 100000000000/0", ctl, dat); end
        bus.mm_tready = 1'b0; bus.sr_tvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        run_cmd(3'b010, 12'h720, 12'h820, 6, 6, 6, 100, 100, -1, 0, 100, cc);
        total++;
        if (mm_mism(12'h720, 6) + wr_mism(12'h820, 6) !== 0 || done_cnt !== 1 || bus.err !== 2'b00) begin
            bad++; $display("FAIL midrun_recover got errors=%0d done=%0d err=%b want 0/1/00", mm_mism(12'h720, 6) + wr_mism(12'h820, 6), done_cnt, bus.err);
        end
    endtask

`ifdef ACC_DMA_TIMEOUT_EN
    task automatic test_timeout();
        int cc;
        run_cmd(3'b001, 12'h900, 12'hA00, 4, 4, 0, 100, 100, -1, 0, 1500, cc);
        total++;
        if (done_cnt !== 1 || bus.err !== 2'b10) begin bad++; $display("FAIL timeout_err got done=%0d err=%b want 1/10", done_cnt, bus.err); end
        total++;
        if (done_cyc - last_hs_cyc < 1020 || done_cyc - last_hs_cyc > 1030) begin
            bad++; $display("FAIL timeout_delay got=%0d want 1020..1030", done_cyc - last_hs_cyc);
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL global_timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "simulation time limit");
    end

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = $urandom;
        bus.cmd_valid = 1'b0; bus.cmd_sel = 3'b000;
        bus.cmd_src_addr = '0; bus.cmd_dst_addr = '0;
        bus.cmd_src_len = '0; bus.cmd_dst_len = '0;
        bus.mem_rd_data = 32'h0; bus.acc_ap_idle = 1'b1;
        bus.mm_tready = 1'b0;
        bus.sr_tvalid = 1'b0; bus.sr_tdata = 32'h0; bus.sr_tlast = 1'b0;
        clear_logs();
        test_reset();
        test_fir();
        test_random_gaps();
        test_wrap();
        test_tlast_err();
        test_idle_wait();
        test_invalid_sel();
        test_zero_len();
        test_reset_mid_run();
`ifdef ACC_DMA_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/acc_dma.md
# acc_dma

Command-driven stream DMA that sits between local word memory and the accelerator wrapper's stream ports. It starts the selected accelerator function and reads a source buffer from memory into the accelerator's AXI-Stream slave. It collects the accelerator's AXI-Stream master output and writes it back to a destination buffer. It reports completion with a done pulse and status.

## Interface
- ADDR_W, 12, word-address width of the memory ports
- LEN_W, 8, width of transfer length fields, in words
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_sel  in  3  one-hot function select: 001 fir, 010 matmul, 100 sorting
- cmd_src_addr / cmd_dst_addr  in  ADDR_W  source / destination base word address
- cmd_src_len / cmd_dst_len  in  LEN_W  words to send / words expected back
- done  out  1  one-cycle completion pulse
- err  out  2  sticky status of last command: bit0 tlast mismatch, bit1 timeout
- mem_rd_en, mem_rd_addr  out  1, ADDR_W  read request; data returns next cycle
- mem_rd_data  in  32  read data
- mem_wr_en, mem_wr_addr, mem_wr_data  out  1, ADDR_W, 32  write port
- acc_ap_start  out  3  function start to accelerator
- acc_ap_idle  in  1  accelerator idle
- mm_tvalid, mm_tdata, mm_tlast  out  1, 32, 1  stream to accelerator
- mm_tready  in  1
- sr_tvalid, sr_tdata, sr_tlast  in  1, 32, 1  stream from accelerator
- sr_tready  out  1

## Operation
- States: IDLE, START, RUN, DONE.
- IDLE: cmd_ready=1. On cmd_valid, latch all cmd fields, clear err, clear counters, and go to START. An invalid cmd_sel (not one-hot) is accepted; the block goes straight to DONE with err=0 and never touches memory or streams.
- START: wait for acc_ap_idle=1. Then drive acc_ap_start=cmd_sel for exactly one cycle and go to RUN.
- RUN, transmit side:
  - 2-entry prefetch FIFO.
  - A read is issued when (fifo count + reads in flight) < 2 and issued < src_len.
  - mem_rd_addr = src_addr + issued, wrapping modulo 2^ADDR_W.
  - mm_tvalid = FIFO non-empty. mm_tdata = FIFO head.
  - mm_tlast=1 on the beat with index src_len-1.
  - Pop on mm_tvalid & mm_tready.
- RUN, receive side:
  - sr_tready=1 while rx_cnt < dst_len.
  - Each sr handshake writes mem at dst_addr + rx_cnt (wrapping), then rx_cnt++.
  - If sr_tlast=1 on a beat other than index dst_len-1, or sr_tlast=0 on index dst_len-1, set err[0]. Transfer still completes on count.
- RUN exits to DONE when sent==src_len and rx_cnt==dst_len. Either length may be 0, which completes that side immediately.
- DONE: done=1 for one cycle, then IDLE.
- Counters are LEN_W+1 bits wide, so no overflow at len = 2^LEN_W-1.

## Timing
- Reset values:
  - state IDLE, cmd_ready=1, done=0, err=0.
  - acc_ap_start=0, mm_tvalid=0, mm_tlast=0, mm_tdata=0, sr_tready=0.
  - mem_rd_en=0, mem_wr_en=0, all addresses and data 0.
- Command accept to acc_ap_start: 1 cycle minimum (IDLE→START, pulse in START if acc_ap_idle=1).
- First mm_tvalid: 2 cycles after entering RUN (issue read, data lands in FIFO).
- Sustained throughput: 1 word/cycle each direction with tready held high.
- mm_tdata and mm_tlast are stable while mm_tvalid=1 and mm_tready=0.
- mem_wr_en/addr/data are registered and asserted the cycle after the sr handshake. Done asserts no earlier than the cycle after the final write.
- A simultaneous FIFO push and pop keeps the count unchanged.
- rst mid-operation: everything returns to reset values immediately and in-flight reads are discarded. The accelerator is reset by the same rst.

## Configuration
- ACC_DMA_TIMEOUT_EN defined:
  - 10-bit watchdog in RUN, cleared on any mm or sr handshake.
  - At 1023 idle cycles: set err[1], drop mm_tvalid/sr_tready, go to DONE.
- Undefined: no watchdog. RUN waits indefinitely and err[1] is always 0.

## Test plan
- fir command, src_len=64, dst_len=64, src_addr=0x100, dst_addr=0x200, both tready high -> one acc_ap_start=001 pulse; 64 beats out with tlast on beat 63; mem[0x200..0x23F] match the model; done pulse; err=0.
- sorting, src_len=10, dst_len=10, random 50% mm_tready/sr_tvalid gaps -> data order preserved, no beat duplicated or lost, mm_tdata stable under stall.
- src_addr=0xFFE, src_len=4 -> reads 0xFFE, 0xFFF, 0x000, 0x001.
- Accelerator asserts sr_tlast on beat 5 of dst_len=16 -> all 16 written, err=01, done pulse.
- acc_ap_idle held low for 20 cycles after command -> acc_ap_start held 0 until idle, then a single pulse; rst asserted mid-RUN -> all outputs at reset values the same cycle.
- With ACC_DMA_TIMEOUT_EN: accelerator never returns data for dst_len=4 -> done 1023 cycles after the last handshake, err=10.
